// File: rtl/piece_bag.sv
// 7-bag tetromino generator feeding a small valid/take FIFO, LFSR seeded with player entropy.
// Optional next-piece preview register enabled by defining PIECE_BAG_PREVIEW_EN.
module piece_bag #(
  parameter int          PIECE_BITS  = 3,
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  entropy_in,
  input  logic                  take,
  output logic [PIECE_BITS-1:0] piece,
  output logic                  piece_valid,
  output logic [PIECE_BITS-1:0] next_piece,
  output logic [2:0]            bag_remaining
);

  // Handshake: piece is the head whenever piece_valid is high; a cycle with
  // take && piece_valid consumes it. take with piece_valid low has no effect.

  localparam int          PTR_W     = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int          CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam logic [6:0]  BAG_FULL  = 7'b1111111;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  logic [15:0]           lfsr_q, lfsr_d;
  logic [6:0]            mask_q, mask_d;
  logic [PIECE_BITS-1:0] mem_q [QUEUE_DEPTH];
  logic [PIECE_BITS-1:0] mem_d [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PIECE_BITS-1:0] piece_q, piece_d;
  logic                  piece_valid_q, piece_valid_d;
  logic [2:0]            cand, sel;
  logic                  push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(QUEUE_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_comb begin
    lfsr_d    = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    lfsr_d[0] = lfsr_d[0] ^ entropy_in;
    if (lfsr_d == 16'h0000) lfsr_d = LFSR_SEED;
  end

  // Cyclic first-set search from the candidate; the mask is never all-zero.
  always_comb begin : sel_logic
    int idx;
    cand = (lfsr_q[2:0] == 3'd7) ? 3'd0 : lfsr_q[2:0];
    sel  = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      idx = int'(cand) + k;
      if (idx >= 7) idx = idx - 7;
      if (mask_q[idx]) sel = 3'(idx);
    end
  end

  assign push = (count_q != CNT_W'(QUEUE_DEPTH)) || take;
  assign pop  = take && (count_q != '0);

  always_comb begin
    mask_d   = mask_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mask_d = mask_q & ~(7'b0000001 << sel);
      if (mask_d == 7'b0000000) mask_d = BAG_FULL;
      mem_d[wr_ptr_q] = PIECE_BITS'(sel) + PIECE_BITS'(1);
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    // Outputs look at the post-update queue so a same-cycle write to an empty head is visible.
    piece_valid_d = (count_d != '0);
    piece_d       = piece_valid_d ? mem_d[rd_ptr_d] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q        <= LFSR_SEED;
      mask_q        <= BAG_FULL;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      piece_q       <= '0;
      piece_valid_q <= 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      lfsr_q        <= lfsr_d;
      mask_q        <= mask_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      piece_q       <= piece_d;
      piece_valid_q <= piece_valid_d;
      for (int i = 0; i < QUEUE_DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef PIECE_BAG_PREVIEW_EN
  logic [PIECE_BITS-1:0] next_piece_q, next_piece_d;

  always_comb begin
    next_piece_d = (count_d >= CNT_W'(2)) ? mem_d[ptr_inc(rd_ptr_d)] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) next_piece_q <= '0;
    else        next_piece_q <= next_piece_d;
  end

  assign next_piece = next_piece_q;
`else
  assign next_piece = '0;
`endif

  always_comb begin
    bag_remaining = 3'd0;
    for (int i = 0; i < 7; i++) bag_remaining = bag_remaining + {2'b00, mask_q[i]};
  end

  assign piece       = piece_q;
  assign piece_valid = piece_valid_q;

endmodule

// File: tb/tb_piece_bag.sv
// Bench for piece_bag: a reference bag/queue model fills exp_q, a negedge monitor pops and compares.
module tb_piece_bag;

  localparam int          DEPTH = 4;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       entropy_in = 1'b0;
  logic       take = 1'b0;
  logic [2:0] piece, next_piece, bag_remaining;
  logic       piece_valid;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_q[$];
  logic [2:0]  pop_log[$];
  logic [2:0]  seq1[$], seq2[$], seq3[$];
  logic [15:0] m_lfsr = SEED;
  logic [6:0]  m_mask = 7'h7f;
  logic [15:0] m_nxt;
  int          m_c, m_idx, m_sel;

  piece_bag #(.PIECE_BITS(3), .QUEUE_DEPTH(DEPTH), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .entropy_in(entropy_in), .take(take),
    .piece(piece), .piece_valid(piece_valid), .next_piece(next_piece),
    .bag_remaining(bag_remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The monitor has already removed the popped head before this edge,
  // so "room in exp_q" covers both the not-full and full-with-take push cases.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr = SEED;
      m_mask = 7'h7f;
      exp_q.delete();
      pop_log.delete();
    end else begin
      if (exp_q.size() < DEPTH) begin
        m_c = int'(m_lfsr[2:0]);
        if (m_c == 7) m_c = 0;
        m_sel = -1;
        for (int k = 0; k < 7; k++) begin
          m_idx = (m_c + k) % 7;
          if (m_sel < 0 && m_mask[m_idx]) m_sel = m_idx;
        end
        exp_q.push_back(3'(m_sel + 1));
        m_mask[m_sel] = 1'b0;
        if (m_mask == 7'h00) m_mask = 7'h7f;
      end
      m_nxt = {1'b0, m_lfsr[15:1]};
      if (m_lfsr[0]) m_nxt = m_nxt ^ 16'hB400;
      m_nxt[0] = m_nxt[0] ^ entropy_in;
      if (m_nxt == 16'h0000) m_nxt = SEED;
      m_lfsr = m_nxt;
    end
  end

  // Monitor: compares outputs every cycle and consumes exp_q on each accepted take.
  always @(negedge clk) begin
    logic [2:0] got;
    logic [6:0] seen;
    check("valid", piece_valid, exp_q.size() > 0);
    check("head", piece, (exp_q.size() > 0) ? int'(exp_q[0]) : 0);
    check("bag_remaining", bag_remaining, $countones(m_mask));
`ifdef PIECE_BAG_PREVIEW_EN
    check("next_piece", next_piece, (exp_q.size() >= 2) ? int'(exp_q[1]) : 0);
`else
    check("next_piece_tied", next_piece, 0);
`endif
    if (take && piece_valid && exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("pop", piece, got);
      pop_log.push_back(piece);
      if (pop_log.size() % 7 == 0) begin
        seen = 7'h00;
        for (int i = pop_log.size() - 7; i < pop_log.size(); i++)
          if (pop_log[i] != 3'd0) seen[int'(pop_log[i]) - 1] = 1'b1;
        check("bag_perm", seen, 7'h7f);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    take = 1'b0;
    entropy_in = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic step(input logic t, input logic e);
    take = t;
    entropy_in = e;
    @(posedge clk);
    #2;
  endtask

  // Fill, 14 pops, 10 more pops against a full queue; optional entropy pulse at cycle 5.
  task automatic run_trace(input bit pulse);
    logic [2:0] prev_next;
    int cyc;
    do_reset();
    check("rst_piece", piece, 0);
    check("rst_valid", piece_valid, 0);
    check("rst_bag", bag_remaining, 7);
    check("rst_next", next_piece, 0);
    step(1'b0, 1'b0);
    check("fill1_valid", piece_valid, 1);
    check("fill1_piece", piece, 2);
    check("fill1_bag", bag_remaining, 6);
    repeat (3) step(1'b0, 1'b0);
    check("fill4_piece", piece, 2);
    check("fill4_bag", bag_remaining, 3);
`ifdef PIECE_BAG_PREVIEW_EN
    check("fill4_next", next_piece, 1);
`else
    check("fill4_next", next_piece, 0);
`endif
    cyc = 4;
    repeat (24) begin
      prev_next = next_piece;
      step(1'b1, pulse && (cyc == 5));
`ifdef PIECE_BAG_PREVIEW_EN
      check("preview_becomes_head", piece, prev_next);
`endif
      cyc++;
    end
    repeat (2) step(1'b0, 1'b0);
  endtask

  initial begin
    bit same12, same13;
    run_trace(1'b0);
    seq1 = pop_log;
    run_trace(1'b0);
    seq2 = pop_log;
    run_trace(1'b1);
    seq3 = pop_log;
    check("pops_run1", seq1.size(), 24);
    check("pops_run3", seq3.size(), 24);
    same12 = (seq1.size() == seq2.size());
    same13 = (seq1.size() == seq3.size());
    for (int i = 0; i < seq1.size(); i++) begin
      if (i < seq2.size() && seq1[i] != seq2[i]) same12 = 1'b0;
      if (i < seq3.size() && seq1[i] != seq3[i]) same13 = 1'b0;
    end
    check("run1_eq_run2", same12, 1);
    check("run3_differs", same13, 0);

    // take on the first cycle with an empty queue must not disturb the sequence.
    do_reset();
    step(1'b1, 1'b0);
    check("early_take_valid", piece_valid, 1);
    check("early_take_piece", piece, 2);
    repeat (3) step(1'b0, 1'b0);
    check("early_take_fill4_piece", piece, 2);
    check("early_take_fill4_bag", bag_remaining, 3);
    repeat (3) step(1'b1, 1'b0);

    // Asynchronous reset mid-cycle, mid-bag.
    #1 rst_n = 1'b0;
    take = 1'b0;
    #1;
    check("async_rst_piece", piece, 0);
    check("async_rst_valid", piece_valid, 0);
    check("async_rst_bag", bag_remaining, 7);
    check("async_rst_next", next_piece, 0);
    do_reset();
    step(1'b0, 1'b0);
    check("restart_piece", piece, 2);
    check("restart_bag", bag_remaining, 6);
    repeat (2) step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
